pio_bidir_irq: RTL and testbench
================================

Name: pio_bidir_irq

Overview:
- Parametrised Avalon-MM slave PIO; next generation of the team's output-only LED PIO.
- Adds:
  - configurable width and reset value;
  - atomic set/clear/toggle of outputs;
  - a synchronised input port with edge capture;
  - a maskable level interrupt.
- Sits on the Nios II data master interconnect; drives LEDs/GPIO and samples switches/keys.

Parameters:
- WIDTH, 10, number of output and input bits (1..32).
- RESET_VALUE, 0, value loaded into the output register on reset (WIDTH bits).
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero-extended above WIDTH.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output register value.
- irq  out  1  active-high level interrupt.

Behaviour:
- Single clock. Reset is asynchronous and active-low, on reset_n.
- Reset values:
  - data_out = RESET_VALUE;
  - irq_mask = 0;
  - edge_cap = 0;
  - sync chain and in_d = 0;
  - warm-up counter = 0;
  - out_port = RESET_VALUE;
  - irq = 0.
- Write strobe: chipselect && !write_n. Writes take effect at the next rising edge.
- Register map (writes use writedata[WIDTH-1:0]):
  - 0 DATA: write loads data_out; read returns data_out.
  - 1 INPUT: read-only; read returns in_sync; writes ignored.
  - 2 IRQMASK: R/W.
  - 3 EDGECAP: read returns edge_cap; writing 1 to a bit clears that bit; writing 0 leaves it unchanged.
  - 4 OUTSET: data_out |= wd.
  - 5 OUTCLR: data_out &= ~wd.
  - 6 OUTTGL: data_out ^= wd.
  - Addresses 4-6 read as 0. Address 7 reads 0; writes to it are ignored.
- Read latency 0: readdata is combinational from address and registers; there are no wait states.
- readdata[31:WIDTH] is always 0.
- Input path:
  - in_port passes through a 2-flop synchroniser to give in_sync; in_d is in_sync delayed by one cycle.
  - If in_port changes before edge N, in_sync shows the new value after edge N+1 and edge_cap sets at edge N+2.
- Edge detect (per bit):
  - rising: in_sync & ~in_d;
  - falling: ~in_sync & in_d;
  - any: in_sync ^ in_d.
- Warm-up:
  - A 2-bit counter increments from 0 to 3 after reset and then saturates.
  - Edge capture is suppressed while the counter is below 3, so inputs held high through reset create no spurious capture.
- Capture and clear:
  - edge_cap bits are sticky until cleared.
  - If an edge is detected on a bit in the same cycle as a write-1-to-clear of that bit, the set wins and the bit stays 1.
- irq = |(edge_cap & irq_mask). It is registered-source combinational, so it rises in the same cycle the capture bit or mask bit becomes 1.
- Masking: clearing a mask bit drops irq but does not clear edge_cap.
- Reset asserted mid-operation immediately forces all reset values, including restarting the warm-up.
- No read side effects.

Test Plan:
- Reset (WIDTH=10, RESET_VALUE=0x155) → out_port=0x155, irq=0; reads of addresses 0-7 return 0x155, 0, 0, 0, 0, 0, 0, 0 (in_port=0).
- Write DATA=0x0F0, then OUTSET 0x003, OUTCLR 0x010, OUTTGL 0x201 → out_port steps 0x0F0 → 0x0F3 → 0x0E3 → 0x2E2, each one cycle after its write.
- EDGE_TYPE=0, IRQMASK=0x001, in_port bit0 goes 0→1 before edge N → INPUT reads 0x001 after N+1; EDGECAP=0x001 and irq=1 after N+2; write EDGECAP 0x001 → irq=0 next cycle.
- Same-cycle edge on bit2 and a write-1-to-clear of bit2 → EDGECAP bit2 stays 1. Separately, clearing IRQMASK → irq=0 while EDGECAP is unchanged.
- in_port=0x3FF held through reset release, EDGE_TYPE=0 → EDGECAP stays 0. Under EDGE_TYPE=2, a 1→0 on bit9 → EDGECAP=0x200.
- Assert reset_n mid-sequence with EDGECAP=0x0FF and out=0x123 → all registers return to reset values asynchronously and irq=0 without a clock edge.

Source files
------------

// File: rtl/pio_bidir_irq_if.sv
// Avalon-MM slave bus bundle for the bidirectional PIO: word address, select,
// active-low write strobe and 32-bit data paths.
interface pio_bidir_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_bidir_irq.sv
// Avalon-MM PIO with atomic set/clear/toggle outputs, a synchronised input port
// with sticky edge capture, and a maskable level interrupt.
module pio_bidir_irq #(
  parameter int unsigned WIDTH       = 10,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_bidir_irq_if.slave   bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RST_OUT = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] in_d_q, in_d_d;
  logic [1:0]       warm_q, warm_d;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] edge_det;
  logic [31:0]      rd;

  always_comb begin
    wr = bus.chipselect && !bus.write_n;
    wd = bus.writedata[WIDTH-1:0];

    sync1_d = in_port;
    sync2_d = sync1_q;
    in_d_d  = sync2_q;
    warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;

    if (EDGE_TYPE == 0) begin
      edge_det = sync2_q & ~in_d_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~sync2_q & in_d_q;
    end else begin
      edge_det = sync2_q ^ in_d_q;
    end

    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;

    if (wr) begin
      case (bus.address)
        3'd0:    data_out_d = wd;
        3'd2:    irq_mask_d = wd;
        3'd3:    edge_cap_d = edge_cap_q & ~wd;
        3'd4:    data_out_d = data_out_q | wd;
        3'd5:    data_out_d = data_out_q & ~wd;
        3'd6:    data_out_d = data_out_q ^ wd;
        default: ;
      endcase
    end

    // Applied after the clear so a same-cycle edge keeps the bit set; the
    // warm-up gate hides the synchroniser filling up after reset.
    if (warm_q == 2'd3) begin
      edge_cap_d = edge_cap_d | edge_det;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RST_OUT;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      in_d_q     <= '0;
      warm_q     <= 2'd0;
    end else begin
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      in_d_q     <= in_d_d;
      warm_q     <= warm_d;
    end
  end

  always_comb begin
    rd = '0;
    case (bus.address)
      3'd0:    rd[WIDTH-1:0] = data_out_q;
      3'd1:    rd[WIDTH-1:0] = sync2_q;
      3'd2:    rd[WIDTH-1:0] = irq_mask_q;
      3'd3:    rd[WIDTH-1:0] = edge_cap_q;
      default: rd = '0;
    endcase
    bus.readdata = rd;
  end

  assign out_port = data_out_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Bench for pio_bidir_irq: a rising-edge and an any-edge instance share one bus
// and input port and are compared against a history-based reference model.
module tb_pio_bidir_irq;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_port;
  logic [W-1:0] out0, out2;
  logic         irq0, irq2;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural registers plus the raw in_port seen before each edge.
  logic [W-1:0] m_out, m_mask, m_cap0, m_cap2;
  logic [W-1:0] hist[$];

  pio_bidir_irq_if bus0 ();
  pio_bidir_irq_if bus2 ();

  assign bus2.address    = bus0.address;
  assign bus2.chipselect = bus0.chipselect;
  assign bus2.write_n    = bus0.write_n;
  assign bus2.writedata  = bus0.writedata;

  pio_bidir_irq #(.WIDTH(W), .RESET_VALUE(32'h155), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave),
    .in_port(in_port), .out_port(out0), .irq(irq0)
  );

  pio_bidir_irq #(.WIDTH(W), .RESET_VALUE(32'h155), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave),
    .in_port(in_port), .out_port(out2), .irq(irq2)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] h(int i);
    if (i < 0 || i >= hist.size()) return '0;
    return hist[i];
  endfunction

  function automatic void model_reset();
    m_out  = W'(32'h155);
    m_mask = '0;
    m_cap0 = '0;
    m_cap2 = '0;
    hist.delete();
  endfunction

  // Value captured at edge k is in_port from two edges earlier against three earlier;
  // capture is only allowed from the fourth edge after reset release.
  function automatic void model_edge();
    logic         wr;
    logic [W-1:0] wd, cur, prev;
    int           k;
    if (!reset_n) begin
      model_reset();
      return;
    end
    wr = bus0.chipselect && !bus0.write_n;
    wd = bus0.writedata[W-1:0];
    hist.push_back(in_port);
    k    = hist.size();
    cur  = h(k - 3);
    prev = h(k - 4);
    if (wr) begin
      case (bus0.address)
        3'd0: m_out = wd;
        3'd2: m_mask = wd;
        3'd3: begin m_cap0 = m_cap0 & ~wd; m_cap2 = m_cap2 & ~wd; end
        3'd4: m_out = m_out | wd;
        3'd5: m_out = m_out & ~wd;
        3'd6: m_out = m_out ^ wd;
        default: ;
      endcase
    end
    if (k >= 4) begin
      m_cap0 = m_cap0 | (cur & ~prev);
      m_cap2 = m_cap2 | (cur ^ prev);
    end
  endfunction

  function automatic logic [31:0] exp_read(logic [2:0] a, logic [W-1:0] cap);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[W-1:0] = m_out;
      3'd1: r[W-1:0] = h(hist.size() - 2);
      3'd2: r[W-1:0] = m_mask;
      3'd3: r[W-1:0] = cap;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus0.address    = a;
    bus0.writedata  = d;
    bus0.chipselect = 1'b1;
    bus0.write_n    = 1'b0;
    tick();
    bus0.chipselect = 1'b0;
    bus0.write_n    = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a,
                            input logic [31:0] e0, input logic [31:0] e2);
    bus0.address = a;
    #1;
    check({tag, "_r"}, bus0.readdata, e0);
    check({tag, "_any"}, bus2.readdata, e2);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_out"}, 32'(out0), 32'(m_out));
    check({tag, "_out_any"}, 32'(out2), 32'(m_out));
    check({tag, "_irq"}, 32'(irq0), 32'(|(m_cap0 & m_mask)));
    check({tag, "_irq_any"}, 32'(irq2), 32'(|(m_cap2 & m_mask)));
    check({tag, "_rd"}, bus0.readdata, exp_read(bus0.address, m_cap0));
    check({tag, "_rd_any"}, bus2.readdata, exp_read(bus0.address, m_cap2));
  endtask

  initial begin
    reset_n         = 1'b0;
    in_port         = '0;
    bus0.address    = '0;
    bus0.chipselect = 1'b0;
    bus0.write_n    = 1'b1;
    bus0.writedata  = '0;
    model_reset();
    #1;
    tick();
    tick();
    reset_n = 1'b1;

    $display("[TB] reset values");
    check("rst_out", 32'(out0), 32'h155);
    check("rst_irq", 32'(irq0), 32'h0);
    for (int a = 0; a < 8; a++) begin
      read_check($sformatf("rst_addr%0d", a), 3'(a), (a == 0) ? 32'h155 : 32'h0,
                 exp_read(3'(a), m_cap2));
    end

    $display("[TB] data and atomic updates");
    bus_write(3'd0, 32'h0F0);
    check("wr_data", 32'(out0), 32'h0F0);
    bus_write(3'd4, 32'h003);
    check("wr_set", 32'(out0), 32'h0F3);
    bus_write(3'd5, 32'h010);
    check("wr_clr", 32'(out0), 32'h0E3);
    bus_write(3'd6, 32'h201);
    check("wr_tgl", 32'(out0), 32'h2E2);
    check_all("wr");

    $display("[TB] rising edge capture and irq");
    bus_write(3'd2, 32'h001);
    in_port = 10'h001;
    tick();
    tick();
    read_check("in_sync", 3'd1, 32'h001, 32'h001);
    read_check("cap_early", 3'd3, 32'h000, 32'h000);
    check("irq_early", 32'(irq0), 32'h0);
    tick();
    read_check("cap_set", 3'd3, 32'h001, 32'h001);
    check("irq_set", 32'(irq0), 32'h1);
    bus_write(3'd3, 32'h001);
    check("irq_cleared", 32'(irq0), 32'h0);
    check_all("cap");

    $display("[TB] set wins over clear, masking");
    in_port = 10'h005;
    tick();
    tick();
    bus_write(3'd3, 32'h004);
    read_check("set_wins", 3'd3, 32'h004, 32'h004);
    bus_write(3'd2, 32'h004);
    check("mask_irq_on", 32'(irq0), 32'h1);
    bus_write(3'd2, 32'h000);
    check("mask_irq_off", 32'(irq0), 32'h0);
    read_check("mask_keep_cap", 3'd3, 32'h004, 32'h004);

    $display("[TB] warm-up and any-edge");
    reset_n = 1'b0;
    model_reset();
    in_port = 10'h3FF;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    read_check("warm_cap", 3'd3, 32'h000, 32'h000);
    check_all("warm");
    in_port = 10'h1FF;
    repeat (3) tick();
    read_check("any_fall", 3'd3, 32'h000, 32'h200);

    $display("[TB] asynchronous reset mid-operation");
    bus_write(3'd0, 32'h123);
    bus_write(3'd2, 32'h0FF);
    in_port = 10'h000;
    repeat (3) tick();
    in_port = 10'h0FF;
    repeat (3) tick();
    read_check("pre_rst_cap", 3'd3, 32'h0FF, exp_read(3'd3, m_cap2));
    check("pre_rst_out", 32'(out0), 32'h123);
    check("pre_rst_irq", 32'(irq0), 32'h1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_out", 32'(out0), 32'h155);
    check("arst_irq", 32'(irq0), 32'h0);
    check("arst_irq_any", 32'(irq2), 32'h0);
    read_check("arst_cap", 3'd3, 32'h000, 32'h000);
    read_check("arst_mask", 3'd2, 32'h000, 32'h000);
    read_check("arst_data", 3'd0, 32'h155, 32'h155);
    in_port = '0;
    tick();
    reset_n = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      bus0.chipselect = 1'($urandom_range(0, 1));
      bus0.write_n    = 1'($urandom_range(0, 1));
      bus0.address    = 3'($urandom_range(0, 7));
      bus0.writedata  = $urandom();
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom());
      tick();
      check_all($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
